// File: rtl/mcu_port_arbiter.sv
// Shares the single memory-controller command port between the CPU cache and the DMA engine.
// Round-robin on contention; ack and read data are steered back to the owner combinationally.
module mcu_port_arbiter #(
    parameter int ADDR_W    = 26,
    parameter int BURST_LEN = 2
) (
    input  logic              MCU_CLK,
    input  logic              RST,
    // cache side
    output logic              dma_mcu_access,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_we,
    input  logic              mem_do_act,
    input  logic [31:0]       mem_dataintomem,
    output logic              mem_ack,
    output logic [31:0]       mem_datafrommem,
    // DMA side
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_ack,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    // memory controller side
    output logic              ctl_act,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [31:0]       ctl_wdata,
    input  logic              ctl_ack,
    input  logic              ctl_rvalid,
    input  logic [31:0]       ctl_rdata,
    // state observation
    output logic [2:0]        o_dbg_state
);

    // Handshake: a requester holds its valid level (mem_do_act / dma_req) until it has been
    // granted, acked and fully drained; the controller acks a command with a one-cycle ctl_ack
    // while ctl_act is high, then returns BURST_LEN one-cycle ctl_rvalid beats for a read.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CPU_CMD   = 3'd1,
        S_CPU_RD    = 3'd2,
        S_CPU_DRAIN = 3'd3,
        S_DMA_CMD   = 3'd4,
        S_DMA_RD    = 3'd5,
        S_DMA_DRAIN = 3'd6
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t     r_state;
    logic       r_last_dma;
    logic       r_access;
    logic [3:0] r_beat_cnt;

    logic w_cpu_req;
    logic w_dma_req;
    logic w_pick_dma;
    logic w_dma_side;

    assign w_cpu_req  = mem_do_act & r_access;
    assign w_dma_req  = dma_req;
    // On contention the side that did not own the port last time wins.
    assign w_pick_dma = w_dma_req & (~w_cpu_req | ~r_last_dma);
    assign w_dma_side = (r_state == S_DMA_CMD) | (r_state == S_DMA_RD) | (r_state == S_DMA_DRAIN);

    always_ff @(posedge MCU_CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_last_dma <= 1'b1;
            r_access   <= 1'b1;
            r_beat_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_req | w_dma_req) begin
                        if (w_pick_dma) begin
                            r_state    <= S_DMA_CMD;
                            r_last_dma <= 1'b1;
                            r_access   <= 1'b0;
                        end else begin
                            r_state    <= S_CPU_CMD;
                            r_last_dma <= 1'b0;
                        end
                    end
                end
                S_CPU_CMD: begin
                    if (ctl_ack) begin
                        r_beat_cnt <= 4'd0;
                        r_state    <= mem_we ? S_CPU_DRAIN : S_CPU_RD;
                    end
                end
                S_CPU_RD: begin
                    if (ctl_rvalid) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= S_CPU_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end
                end
                S_CPU_DRAIN: begin
                    if (!mem_do_act) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DMA_CMD: begin
                    if (ctl_ack) begin
                        r_beat_cnt <= 4'd0;
                        r_state    <= dma_we ? S_DMA_DRAIN : S_DMA_RD;
                    end
                end
                S_DMA_RD: begin
                    if (ctl_rvalid) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= S_DMA_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end
                end
                S_DMA_DRAIN: begin
                    if (!dma_req) begin
                        r_state  <= S_IDLE;
                        r_access <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_access <= 1'b1;
                end
            endcase
        end
    end

    // Command is only presented while waiting for ack, so a lingering request is never reissued.
    assign ctl_act   = (r_state == S_CPU_CMD) | (r_state == S_DMA_CMD);
    assign ctl_we    = w_dma_side ? dma_we    : mem_we;
    assign ctl_addr  = w_dma_side ? dma_addr  : mem_addr;
    assign ctl_wdata = w_dma_side ? dma_wdata : mem_dataintomem;

    assign mem_ack         = ctl_ack & (r_state == S_CPU_CMD);
    assign dma_ack         = ctl_ack & (r_state == S_DMA_CMD);
    assign dma_rvalid      = ctl_rvalid & (r_state == S_DMA_RD);
    assign mem_datafrommem = ctl_rdata;
    assign dma_rdata       = ctl_rdata;

    assign dma_mcu_access = r_access;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mcu_port_arbiter.sv
// Directed bench for mcu_port_arbiter: solo cache/DMA transfers, round-robin order,
// reset mid-burst and spurious controller strobes.
module tb_mcu_port_arbiter;

    localparam int ADDR_W = 26;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CPU_CMD   = 3'd1;
    localparam logic [2:0] ST_CPU_RD    = 3'd2;
    localparam logic [2:0] ST_CPU_DRAIN = 3'd3;
    localparam logic [2:0] ST_DMA_CMD   = 3'd4;
    localparam logic [2:0] ST_DMA_RD    = 3'd5;
    localparam logic [2:0] ST_DMA_DRAIN = 3'd6;

    logic              MCU_CLK;
    logic              RST;
    logic              dma_mcu_access;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_do_act;
    logic [31:0]       mem_dataintomem;
    logic              mem_ack;
    logic [31:0]       mem_datafrommem;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_ack;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;
    logic              ctl_act;
    logic              ctl_we;
    logic [ADDR_W-1:0] ctl_addr;
    logic [31:0]       ctl_wdata;
    logic              ctl_ack;
    logic              ctl_rvalid;
    logic [31:0]       ctl_rdata;
    logic [2:0]        o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    mcu_port_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(2)) dut (
        .MCU_CLK         (MCU_CLK),
        .RST             (RST),
        .dma_mcu_access  (dma_mcu_access),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_do_act      (mem_do_act),
        .mem_dataintomem (mem_dataintomem),
        .mem_ack         (mem_ack),
        .mem_datafrommem (mem_datafrommem),
        .dma_req         (dma_req),
        .dma_we          (dma_we),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_ack         (dma_ack),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .ctl_act         (ctl_act),
        .ctl_we          (ctl_we),
        .ctl_addr        (ctl_addr),
        .ctl_wdata       (ctl_wdata),
        .ctl_ack         (ctl_ack),
        .ctl_rvalid      (ctl_rvalid),
        .ctl_rdata       (ctl_rdata),
        .o_dbg_state     (o_dbg_state)
    );

    // clock / reset
    initial MCU_CLK = 1'b0;
    always #5 MCU_CLK = ~MCU_CLK;

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge MCU_CLK);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        mem_addr = '0; mem_we = 1'b0; mem_do_act = 1'b0; mem_dataintomem = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = 32'h0;
        ctl_ack = 1'b0; ctl_rvalid = 1'b0; ctl_rdata = 32'h0;

        // reset state
        #3;
        chk("rst_state",  {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        chk("rst_access", {31'd0, dma_mcu_access}, 32'd1);
        chk("rst_ctl_act", {31'd0, ctl_act}, 32'd0);
        chk("rst_acks",   {30'd0, mem_ack, dma_ack}, 32'd0);
        chk("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
        tick();
        RST = 1'b0;
        tick();

        // 1: cache read alone
        mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 26'h0000123;
        tick();
        chk("t1_state_cmd", {29'd0, o_dbg_state}, {29'd0, ST_CPU_CMD});
        chk("t1_ctl_act",   {31'd0, ctl_act}, 32'd1);
        chk("t1_ctl_addr",  {6'd0, ctl_addr}, 32'h0000123);
        chk("t1_ctl_we",    {31'd0, ctl_we}, 32'd0);
        tick();
        tick();
        ctl_ack = 1'b1;
        settle();
        chk("t1_mem_ack", {31'd0, mem_ack}, 32'd1);
        chk("t1_dma_ack", {31'd0, dma_ack}, 32'd0);
        tick();
        ctl_ack = 1'b0;
        settle();
        chk("t1_state_rd",  {29'd0, o_dbg_state}, {29'd0, ST_CPU_RD});
        chk("t1_ack_pulse", {31'd0, mem_ack}, 32'd0);
        chk("t1_act_off",   {31'd0, ctl_act}, 32'd0);
        ctl_rvalid = 1'b1; ctl_rdata = 32'hA1A1A1A1;
        settle();
        chk("t1_beat1_data", mem_datafrommem, 32'hA1A1A1A1);
        chk("t1_beat1_dmarv", {31'd0, dma_rvalid}, 32'd0);
        tick();
        ctl_rdata = 32'hA2A2A2A2;
        settle();
        chk("t1_beat2_data", mem_datafrommem, 32'hA2A2A2A2);
        chk("t1_state_rd2",  {29'd0, o_dbg_state}, {29'd0, ST_CPU_RD});
        tick();
        ctl_rvalid = 1'b0;
        chk("t1_state_drain", {29'd0, o_dbg_state}, {29'd0, ST_CPU_DRAIN});
        chk("t1_linger0_act", {31'd0, ctl_act}, 32'd0);
        tick();
        chk("t1_linger1_act", {31'd0, ctl_act}, 32'd0);
        mem_do_act = 1'b0;
        tick();
        chk("t1_state_idle", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        chk("t1_idle_act",   {31'd0, ctl_act}, 32'd0);

        // 2: DMA write alone
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 26'h0ABCDEF; dma_wdata = 32'hDEADBEEF;
        tick();
        chk("t2_state_cmd", {29'd0, o_dbg_state}, {29'd0, ST_DMA_CMD});
        chk("t2_access",    {31'd0, dma_mcu_access}, 32'd0);
        chk("t2_ctl_wdata", ctl_wdata, 32'hDEADBEEF);
        chk("t2_ctl_addr",  {6'd0, ctl_addr}, 32'h0ABCDEF);
        chk("t2_ctl_we",    {31'd0, ctl_we}, 32'd1);
        tick();
        ctl_ack = 1'b1;
        settle();
        chk("t2_dma_ack", {31'd0, dma_ack}, 32'd1);
        chk("t2_mem_ack", {31'd0, mem_ack}, 32'd0);
        tick();
        ctl_ack = 1'b0;
        chk("t2_state_drain", {29'd0, o_dbg_state}, {29'd0, ST_DMA_DRAIN});
        tick();
        chk("t2_access_hold", {31'd0, dma_mcu_access}, 32'd0);
        dma_req = 1'b0;
        tick();
        chk("t2_state_idle", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        chk("t2_access_back", {31'd0, dma_mcu_access}, 32'd1);

        // 3: contention from reset (last owner DMA), then alternation
        RST = 1'b1;
        settle();
        RST = 1'b0;
        mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 26'h0000AAA; mem_dataintomem = 32'h0C0C0C0C;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 26'h0000BBB; dma_wdata = 32'h0D0D0D0D;
        tick();
        chk("t3_first_cpu",  {29'd0, o_dbg_state}, {29'd0, ST_CPU_CMD});
        chk("t3_first_wdata", ctl_wdata, 32'h0C0C0C0C);
        ctl_ack = 1'b1;
        settle();
        chk("t3_first_ack", {31'd0, mem_ack}, 32'd1);
        tick();
        ctl_ack = 1'b0;
        mem_do_act = 1'b0;
        tick();
        chk("t3_idle1", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        mem_do_act = 1'b1;
        tick();
        chk("t3_second_dma",  {29'd0, o_dbg_state}, {29'd0, ST_DMA_CMD});
        chk("t3_second_wdata", ctl_wdata, 32'h0D0D0D0D);
        ctl_ack = 1'b1;
        settle();
        chk("t3_second_ack", {31'd0, dma_ack}, 32'd1);
        chk("t3_loser_noack", {31'd0, mem_ack}, 32'd0);
        tick();
        ctl_ack = 1'b0;
        chk("t3_dma_drain", {29'd0, o_dbg_state}, {29'd0, ST_DMA_DRAIN});
        dma_req = 1'b0;
        tick();
        chk("t3_idle2", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        dma_req = 1'b1;
        tick();
        chk("t3_third_cpu", {29'd0, o_dbg_state}, {29'd0, ST_CPU_CMD});
        ctl_ack = 1'b1;
        tick();
        ctl_ack = 1'b0;
        mem_do_act = 1'b0; dma_req = 1'b0;
        tick();
        chk("t3_idle3", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});

        // 4: DMA read burst, with a stray ack during the read
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 26'h0000456;
        tick();
        chk("t4_state_cmd", {29'd0, o_dbg_state}, {29'd0, ST_DMA_CMD});
        ctl_ack = 1'b1;
        settle();
        chk("t4_dma_ack", {31'd0, dma_ack}, 32'd1);
        tick();
        ctl_ack = 1'b0;
        chk("t4_state_rd", {29'd0, o_dbg_state}, {29'd0, ST_DMA_RD});
        ctl_ack = 1'b1;
        settle();
        chk("t4_stray_ack", {30'd0, mem_ack, dma_ack}, 32'd0);
        tick();
        ctl_ack = 1'b0;
        chk("t4_state_after_ack", {29'd0, o_dbg_state}, {29'd0, ST_DMA_RD});
        ctl_rvalid = 1'b1; ctl_rdata = 32'h11111111;
        settle();
        chk("t4_beat1_rv",   {31'd0, dma_rvalid}, 32'd1);
        chk("t4_beat1_data", dma_rdata, 32'h11111111);
        chk("t4_beat1_mack", {31'd0, mem_ack}, 32'd0);
        tick();
        ctl_rdata = 32'h22222222;
        settle();
        chk("t4_beat2_rv",   {31'd0, dma_rvalid}, 32'd1);
        chk("t4_beat2_data", dma_rdata, 32'h22222222);
        tick();
        ctl_rvalid = 1'b0;
        settle();
        chk("t4_state_drain", {29'd0, o_dbg_state}, {29'd0, ST_DMA_DRAIN});
        chk("t4_rv_off",      {31'd0, dma_rvalid}, 32'd0);
        dma_req = 1'b0;
        tick();
        chk("t4_access_back", {31'd0, dma_mcu_access}, 32'd1);

        // 6: spurious beat while idle
        ctl_rvalid = 1'b1; ctl_rdata = 32'h33333333;
        settle();
        chk("t6_idle_rv",  {31'd0, dma_rvalid}, 32'd0);
        chk("t6_idle_act", {31'd0, ctl_act}, 32'd0);
        tick();
        ctl_rvalid = 1'b0;
        chk("t6_idle_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});

        // 5: reset during a cache read after the first beat
        mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 26'h0000789;
        tick();
        ctl_ack = 1'b1;
        tick();
        ctl_ack = 1'b0;
        chk("t5_state_rd", {29'd0, o_dbg_state}, {29'd0, ST_CPU_RD});
        ctl_rvalid = 1'b1; ctl_rdata = 32'h44444444;
        tick();
        ctl_rvalid = 1'b0;
        RST = 1'b1; mem_do_act = 1'b0;
        settle();
        chk("t5_rst_state",  {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        chk("t5_rst_access", {31'd0, dma_mcu_access}, 32'd1);
        chk("t5_rst_act",    {31'd0, ctl_act}, 32'd0);
        tick();
        RST = 1'b0;
        ctl_rvalid = 1'b1; ctl_rdata = 32'h55555555;
        settle();
        chk("t5_stray_rv", {31'd0, dma_rvalid}, 32'd0);
        tick();
        ctl_rvalid = 1'b0;
        chk("t5_stray_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
